// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the cascaded digit counter.
package stopwatch_pkg;

  localparam int DEF_DW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/digit_cell.sv
// One counter digit: clamped preload, wrap-around increment/decrement.
module digit_cell
  import stopwatch_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          dir,
  input  logic [DW-1:0] max,
  input  logic          load,
  input  logic [DW-1:0] ld_val,
  output logic [DW-1:0] val,
  output logic          at_max,
  output logic          at_zero
);

  logic [DW-1:0] val_q, val_d;

  assign at_max  = (val_q == max);
  assign at_zero = (val_q == '0);
  assign val     = val_q;

  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = (ld_val > max) ? max : ld_val;
    end else if (step) begin
      if (dir) val_d = at_max  ? '0  : val_q + DW'(1);
      else     val_d = at_zero ? max  : val_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) val_q <= '0;
    else     val_q <= val_d;
  end

endmodule

// File: rtl/digit_chain_counter.sv
// Cascaded mixed-radix counter with run/stop FSM, wrap-or-halt terminal handling.
module digit_chain_counter
  import stopwatch_pkg::*;
#(
  parameter int                  NDIG    = 4,
  parameter int                  DW      = DEF_DW,
  parameter logic [NDIG*DW-1:0]  DIG_MAX = 16'h5959
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               TICK,
  input  logic               M,
  input  logic               WRAP,
  input  logic               START,
  input  logic               STOP,
  input  logic               LD,
  input  logic [NDIG*DW-1:0] D,
  output logic [NDIG*DW-1:0] Q,
  output logic               TC,
  output logic               DONE,
  output logic               BUSY
);

  state_e state_q, state_d;
  logic   tc_q, tc_d;
  logic   done_q, done_d;

  logic [NDIG-1:0] at_max, at_zero, step;
  logic [NDIG:0]   chain_max, chain_zero;
  logic            terminal, count_en, advance;

  // chain_*[i] is high when every digit below i sits at max / zero
  always_comb begin
    chain_max[0]  = 1'b1;
    chain_zero[0] = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      chain_max[i+1]  = chain_max[i]  & at_max[i];
      chain_zero[i+1] = chain_zero[i] & at_zero[i];
    end
  end

  assign terminal = M ? chain_max[NDIG] : chain_zero[NDIG];
  assign count_en = (state_q == RUN) && TICK && !STOP && !LD;
  // A wrap is the ordinary cascade rolling every digit; only a halt suppresses stepping.
  assign advance  = count_en && !(terminal && !WRAP);

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    logic [DW-1:0] val;

    assign step[g] = advance && (M ? chain_max[g] : chain_zero[g]);

    digit_cell #(.DW(DW)) u_cell (
      .clk    (CLK),
      .rst    (RST),
      .step   (step[g]),
      .dir    (M),
      .max    (DIG_MAX[g*DW +: DW]),
      .load   (LD),
      .ld_val (D[g*DW +: DW]),
      .val    (val),
      .at_max (at_max[g]),
      .at_zero(at_zero[g])
    );

    assign Q[g*DW +: DW] = val;
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (LD) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (START && !STOP) state_d = RUN;
        RUN: begin
          if (STOP) begin
            state_d = IDLE;
          end else if (TICK && terminal) begin
            tc_d = 1'b1;
            if (!WRAP) begin
              state_d = HALT;
              done_d  = 1'b1;
            end
          end
        end
        HALT:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign TC   = tc_q;
  assign DONE = done_q;
  assign BUSY = (state_q == RUN);

endmodule

// File: tb/tb_digit_chain_counter.sv
// Scoreboard bench: index-based reference model feeds a queue, monitor compares each cycle.
module tb_digit_chain_counter;

  localparam int NDIG = 4;
  localparam int DW   = 4;
  localparam logic [15:0] DMAX = 16'h5959;

  logic        CLK = 1'b0;
  logic        RST, TICK, M, WRAP, START, STOP, LD;
  logic [15:0] D, Q;
  logic        TC, DONE, BUSY;

  always #5 CLK = ~CLK;

  digit_chain_counter #(.NDIG(NDIG), .DW(DW), .DIG_MAX(DMAX)) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .M(M), .WRAP(WRAP), .START(START),
    .STOP(STOP), .LD(LD), .D(D), .Q(Q), .TC(TC), .DONE(DONE), .BUSY(BUSY)
  );

  typedef struct {
    logic [15:0] q;
    logic        tc;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the count is a single integer position in a mixed-radix space.
  int mq;
  int mst;   // 0 idle, 1 run, 2 halt
  bit mdone;

  function automatic int radix(int i);
    logic [15:0] m;
    m = DMAX;
    return int'(m[i*DW +: DW]) + 1;
  endfunction

  function automatic int total();
    int t = 1;
    for (int i = 0; i < NDIG; i++) t *= radix(i);
    return t;
  endfunction

  function automatic int to_idx(logic [15:0] v);
    int idx = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      int dg = int'(v[i*DW +: DW]);
      if (dg > radix(i) - 1) dg = radix(i) - 1;
      idx = idx * radix(i) + dg;
    end
    return idx;
  endfunction

  function automatic logic [15:0] to_q(int idx);
    logic [15:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[i*DW +: DW] = 4'(idx % radix(i));
      idx = idx / radix(i);
    end
    return r;
  endfunction

  task automatic model_step(output exp_t e);
    bit tc = 1'b0;
    if (RST) begin
      mq = 0; mst = 0; mdone = 1'b0;
    end else if (LD) begin
      mq = to_idx(D); mst = 0; mdone = 1'b0;
    end else begin
      case (mst)
        0: if (START && !STOP) mst = 1;
        1: begin
          if (STOP) mst = 0;
          else if (TICK) begin
            if ((M && mq == total() - 1) || (!M && mq == 0)) begin
              tc = 1'b1;
              if (WRAP) mq = M ? 0 : total() - 1;
              else begin mst = 2; mdone = 1'b1; end
            end else begin
              mq = M ? mq + 1 : mq - 1;
            end
          end
        end
        default: ;
      endcase
    end
    e.q = to_q(mq); e.tc = tc; e.done = mdone; e.busy = (mst == 1);
  endtask

  task automatic cyc(input bit rst, input bit ld, input logic [15:0] d, input bit tick,
                     input bit m, input bit wrap, input bit start, input bit stop);
    exp_t e;
    @(negedge CLK);
    RST = rst; LD = ld; D = d; TICK = tick; M = m; WRAP = wrap; START = start; STOP = stop;
    model_step(e);
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("Q",    Q,           e.q);
      chk("TC",   16'(TC),     16'(e.tc));
      chk("DONE", 16'(DONE),   16'(e.done));
      chk("BUSY", 16'(BUSY),   16'(e.busy));
    end
  end

  initial begin
    bit m_r, w_r;
    RST = 1'b1; LD = 1'b0; D = '0; TICK = 1'b0; M = 1'b1; WRAP = 1'b0; START = 1'b0; STOP = 1'b0;
    mq = 0; mst = 0; mdone = 1'b0;

    // args: rst ld d tick m wrap start stop
    cyc(1, 0, 16'h0000, 0, 1, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1, 0, 0, 0);

    // up wrap from 5958
    cyc(0, 1, 16'h5958, 0, 1, 1, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1, 1, 1, 0);
    cyc(0, 0, 16'h0000, 1, 1, 1, 0, 0);
    cyc(0, 0, 16'h0000, 1, 1, 1, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1, 1, 0, 0);

    // down borrow, then down to terminal and halt
    cyc(0, 1, 16'h0100, 0, 0, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 0, 1, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0, 0, 0);
    cyc(0, 1, 16'h0001, 0, 0, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 0, 0, 1, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0, 0, 0);
    cyc(0, 0, 16'h0000, 1, 0, 0, 1, 0);
    cyc(0, 0, 16'h0000, 0, 1, 0, 1, 0);

    // clamped load
    cyc(0, 1, 16'h7A9F, 0, 1, 0, 0, 0);

    // stop/start interplay
    cyc(0, 0, 16'h0000, 0, 1, 0, 1, 0);
    cyc(0, 0, 16'h0000, 1, 1, 0, 0, 1);
    cyc(0, 0, 16'h0000, 0, 1, 0, 1, 1);
    cyc(0, 0, 16'h0000, 1, 1, 0, 1, 0);
    cyc(0, 0, 16'h0000, 0, 1, 0, 0, 0);

    // reset mid-run with tick
    cyc(0, 1, 16'h0312, 0, 1, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1, 0, 1, 0);
    cyc(0, 0, 16'h0000, 1, 1, 0, 0, 0);
    cyc(1, 0, 16'h0000, 1, 1, 0, 0, 0);
    cyc(0, 0, 16'h0000, 0, 1, 0, 0, 0);

    // randomized traffic biased toward terminal values
    m_r = 1'b1; w_r = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      bit r, l, t, s, p;
      logic [15:0] dv;
      r = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 24) == 0);
      t = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 15) == 0) m_r = ~m_r;
      if ($urandom_range(0, 31) == 0) w_r = ~w_r;
      case ($urandom_range(0, 5))
        0: dv = 16'h5959;
        1: dv = 16'h0000;
        2: dv = 16'h5958;
        3: dv = 16'h0001;
        default: dv = 16'($urandom);
      endcase
      if (mst == 1 && t) s = 1'b0;
      cyc(r, l, dv, t, m_r, w_r, s, p);
    end

    repeat (3) @(negedge CLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
